// File: rtl/ext_mem_responder.sv
// rtl/ext_mem_responder.sv - far-end responder for the regblock external-memory window
// Small word-addressed memory answering req strobes with rd_ack/wr_ack after ACK_LATENCY cycles.
module ext_mem_responder #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int ACK_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hwif_out_mm_req,
    input  logic                  hwif_out_mm_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] hwif_out_mm_addr,
    input  logic [DATA_WIDTH-1:0] hwif_out_mm_wr_data,
    input  logic [DATA_WIDTH-1:0] hwif_out_mm_wr_biten,
    output logic                  hwif_in_mm_rd_ack,
    output logic [DATA_WIDTH-1:0] hwif_in_mm_rd_data,
    output logic                  hwif_in_mm_wr_ack,
    output logic                  busy,
    output logic                  overrun
);

    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int IDX_W     = ADDR_WIDTH - LANE_BITS;
    localparam int WORDS     = 2 ** IDX_W;
    localparam logic [3:0] LAT_M1 = 4'(ACK_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_e;

    state_e                state_q,   state_d;
    logic [3:0]            cnt_q,     cnt_d;
    logic                  op_wr_q,   op_wr_d;
    logic [DATA_WIDTH-1:0] hold_q,    hold_d;
    logic                  rd_ack_q,  rd_ack_d;
    logic                  wr_ack_q,  wr_ack_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  busy_q,    busy_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [DATA_WIDTH-1:0] mem_d [WORDS];

    logic             accept;
    logic [IDX_W-1:0] idx;

    // Byte-offset bits drop out of the shift; sub-word addresses alias to their word.
    assign idx = IDX_W'(hwif_out_mm_addr >> LANE_BITS);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        hold_d    = hold_q;
        overrun_d = overrun_q;
        mem_d     = mem_q;
        accept    = hwif_out_mm_req && (state_q == ST_IDLE || state_q == ST_ACK);

        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                    cnt_d   = 4'd0;
                end
                if (hwif_out_mm_req) begin
                    overrun_d = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = state_q;
        endcase

        // Writes commit on the accept edge, so a later read always sees them.
        if (accept) begin
            op_wr_d = hwif_out_mm_req_is_wr;
            if (hwif_out_mm_req_is_wr) begin
                mem_d[idx] = (mem_q[idx] & ~hwif_out_mm_wr_biten)
                           | (hwif_out_mm_wr_data & hwif_out_mm_wr_biten);
            end else begin
                hold_d = mem_q[idx];
            end
            if (ACK_LATENCY == 1) begin
                state_d = ST_ACK;
            end else begin
                cnt_d   = LAT_M1;
                state_d = ST_WAIT;
            end
        end

        rd_ack_d  = (state_d == ST_ACK) && !op_wr_d;
        wr_ack_d  = (state_d == ST_ACK) && op_wr_d;
        rd_data_d = rd_ack_d ? hold_d : '0;
        busy_d    = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_wr_q   <= 1'b0;
            hold_q    <= '0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_wr_q   <= op_wr_d;
            hold_q    <= hold_d;
            rd_ack_q  <= rd_ack_d;
            wr_ack_q  <= wr_ack_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign hwif_in_mm_rd_ack  = rd_ack_q;
    assign hwif_in_mm_wr_ack  = wr_ack_q;
    assign hwif_in_mm_rd_data = rd_data_q;
    assign busy               = busy_q;
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// tb/tb_ext_mem_responder.sv - bench for ext_mem_responder at latencies 2, 1, 3 and 15
module tb_ext_mem_responder;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_i = '1;
    logic [NI-1:0] req_i = '0;
    logic [NI-1:0] wr_i  = '0;
    logic [4:0]    addr_i  [NI];
    logic [31:0]   data_i  [NI];
    logic [31:0]   biten_i [NI];
    logic [NI-1:0] rd_ack_o, wr_ack_o, busy_o, ovr_o;
    logic [31:0]   rd_data_o [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ext_mem_responder #(
            .ADDR_WIDTH (5),
            .DATA_WIDTH (32),
            .ACK_LATENCY(g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 3 : 15)
        ) u_dut (
            .clk                  (clk),
            .rst                  (rst_i[g]),
            .hwif_out_mm_req      (req_i[g]),
            .hwif_out_mm_req_is_wr(wr_i[g]),
            .hwif_out_mm_addr     (addr_i[g]),
            .hwif_out_mm_wr_data  (data_i[g]),
            .hwif_out_mm_wr_biten (biten_i[g]),
            .hwif_in_mm_rd_ack    (rd_ack_o[g]),
            .hwif_in_mm_rd_data   (rd_data_o[g]),
            .hwif_in_mm_wr_ack    (wr_ack_o[g]),
            .busy                 (busy_o[g]),
            .overrun              (ovr_o[g])
        );
    end

    function automatic int lat(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    // Reference model: one outstanding access per instance, tracked by its ack cycle.
    logic [31:0] mem_m [NI][8];
    bit          pend    [NI];
    int          ack_cyc [NI];
    bit          ack_wr  [NI];
    logic [31:0] ack_data[NI];
    bit          ovr_m   [NI];
    bit          tbl_val [NI];
    logic [31:0] tbl_exp [NI];
    int          rdack_cnt[NI];

    bit          p_rst[NI], p_req[NI], p_wr[NI], p_tv[NI];
    logic [4:0]  p_addr[NI];
    logic [31:0] p_data[NI], p_biten[NI], p_te[NI];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] biten;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", name, i, cyc, act, exp);
        end
    endtask

    task automatic check_inst(input int i);
        bit er, ew;
        er = pend[i] && ack_cyc[i] == cyc && !ack_wr[i];
        ew = pend[i] && ack_cyc[i] == cyc && ack_wr[i];
        chk("rd_ack",  i, 32'(rd_ack_o[i]), 32'(er));
        chk("wr_ack",  i, 32'(wr_ack_o[i]), 32'(ew));
        chk("rd_data", i, rd_data_o[i], er ? ack_data[i] : 32'h0);
        chk("busy",    i, 32'(busy_o[i]), 32'(pend[i] && cyc < ack_cyc[i]));
        chk("overrun", i, 32'(ovr_o[i]), 32'(ovr_m[i]));
        if (er && tbl_val[i]) begin
            chk("tbl_rd_data", i, rd_data_o[i], tbl_exp[i]);
            tbl_val[i] = 0;
        end
        if (rd_ack_o[i]) rdack_cnt[i]++;
    endtask

    task automatic model_apply(input int i);
        int w;
        if (p_rst[i]) begin
            for (int k = 0; k < 8; k++) mem_m[i][k] = '0;
            pend[i] = 0; ovr_m[i] = 0; tbl_val[i] = 0;
        end else if (p_req[i]) begin
            if (pend[i]) begin
                ovr_m[i] = 1;
            end else begin
                w = int'(p_addr[i]) / 4;
                if (p_wr[i]) mem_m[i][w] = (mem_m[i][w] & ~p_biten[i]) | (p_data[i] & p_biten[i]);
                else         ack_data[i] = mem_m[i][w];
                pend[i] = 1; ack_wr[i] = p_wr[i]; ack_cyc[i] = cyc + lat(i);
                if (p_tv[i]) begin tbl_val[i] = 1; tbl_exp[i] = p_te[i]; end
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) if (chk_en) check_inst(i);
        for (int i = 0; i < NI; i++) if (pend[i] && ack_cyc[i] <= cyc) pend[i] = 0;
        for (int i = 0; i < NI; i++) begin
            rst_i[i]   = p_rst[i];
            req_i[i]   = p_req[i];
            wr_i[i]    = p_wr[i];
            addr_i[i]  = p_addr[i];
            data_i[i]  = p_data[i];
            biten_i[i] = p_biten[i];
            model_apply(i);
            p_rst[i] = 0; p_req[i] = 0; p_wr[i] = 0; p_tv[i] = 0;
            p_addr[i] = '0; p_data[i] = '0; p_biten[i] = '0;
        end
    endtask

    task automatic plan(input int i, input bit wr, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] b);
        p_req[i] = 1; p_wr[i] = wr; p_addr[i] = a; p_data[i] = d; p_biten[i] = b;
    endtask

    task automatic plan_rd(input int i, input logic [4:0] a, input logic [31:0] e);
        plan(i, 0, a, '0, '0);
        p_tv[i] = 1; p_te[i] = e;
    endtask

    task automatic idle(input int n);
        repeat (n) run_cycle();
    endtask

    vec_t vecs [7];
    int   base;

    initial begin
        for (int i = 0; i < NI; i++) begin
            addr_i[i] = '0; data_i[i] = '0; biten_i[i] = '0;
            p_rst[i] = 1; p_req[i] = 0; p_wr[i] = 0; p_tv[i] = 0;
            p_addr[i] = '0; p_data[i] = '0; p_biten[i] = '0; p_te[i] = '0;
            rdack_cnt[i] = 0;
        end
        run_cycle();
        for (int i = 0; i < NI; i++) p_rst[i] = 1;
        run_cycle();
        chk_en = 1;
        idle(8);

        vecs[0] = '{1'b1, 5'h04, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0};
        vecs[1] = '{1'b0, 5'h04, 32'h0,        32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'h0C, 32'h12345678, 32'hFFFFFFFF, 32'h0};
        vecs[3] = '{1'b1, 5'h0C, 32'hFFFFFFFF, 32'h0000FF00, 32'h0};
        vecs[4] = '{1'b0, 5'h0C, 32'h0,        32'h0,        32'h1234FF78};
        vecs[5] = '{1'b0, 5'h0E, 32'h0,        32'h0,        32'h1234FF78};
        vecs[6] = '{1'b0, 5'h00, 32'h0,        32'h0,        32'h00000000};
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].wr) plan(0, 1, vecs[v].addr, vecs[v].data, vecs[v].biten);
            else            plan_rd(0, vecs[v].addr, vecs[v].exp);
            run_cycle();
            idle(lat(0));
        end

        // Back-to-back on latency 2: each new req lands in the previous ack cycle.
        plan(0, 1, 5'h14, 32'h00000011, 32'hFFFFFFFF); run_cycle(); run_cycle();
        plan_rd(0, 5'h14, 32'h00000011);               run_cycle(); run_cycle();
        plan_rd(0, 5'h04, 32'hDEADBEEF);               run_cycle();
        idle(3);
        chk("b2b_overrun", 0, 32'(ovr_o[0]), 32'h0);

        // Latency 1: four writes then four reads, one per cycle.
        for (int k = 0; k < 4; k++) begin
            plan(1, 1, 5'(k * 4), 32'h100 + 32'(k), 32'hFFFFFFFF); run_cycle();
        end
        base = rdack_cnt[1];
        for (int k = 0; k < 4; k++) begin
            plan_rd(1, 5'(k * 4), 32'h100 + 32'(k)); run_cycle();
        end
        run_cycle();
        chk("lat1_ack_count", 1, 32'(rdack_cnt[1] - base), 32'd4);
        chk("lat1_overrun", 1, 32'(ovr_o[1]), 32'h0);
        idle(2);

        // Overrun: write during WAIT of a read is dropped.
        plan_rd(0, 5'h04, 32'hDEADBEEF);               run_cycle();
        plan(0, 1, 5'h04, 32'h00000055, 32'hFFFFFFFF); run_cycle();
        idle(3);
        plan_rd(0, 5'h04, 32'hDEADBEEF); run_cycle();
        idle(3);
        chk("overrun_set", 0, 32'(ovr_o[0]), 32'h1);
        idle(6);
        chk("overrun_held", 0, 32'(ovr_o[0]), 32'h1);

        // Reset during WAIT of a write to word 2.
        plan(0, 1, 5'h08, 32'h00000077, 32'hFFFFFFFF); run_cycle();
        p_rst[0] = 1; run_cycle();
        run_cycle();
        chk("rst_busy", 0, 32'(busy_o[0]), 32'h0);
        idle(3);
        plan_rd(0, 5'h08, 32'h0); run_cycle();
        idle(3);
        chk("rst_overrun_clear", 0, 32'(ovr_o[0]), 32'h0);

        // Random traffic on all instances against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                bit ok;
                logic [31:0] b;
                ok = !pend[i] || ack_cyc[i] <= cyc + 1;
                if ($urandom_range(0, 799) == 0) begin
                    p_rst[i] = 1;
                end else if (ok ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 3)) begin
                    case ($urandom_range(0, 2))
                        0:       b = 32'hFFFFFFFF;
                        1:       b = 32'hFF << (8 * $urandom_range(0, 3));
                        default: b = $urandom;
                    endcase
                    plan(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, b);
                end
            end
            run_cycle();
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_mem_responder.md
Name: ext_mem_responder

Overview:
- Downstream responder for the regblock external-memory (mm) interface.
- Consumes the single-cycle req / req_is_wr / addr / wr_data / wr_biten strobes from the generated register block.
- Returns rd_ack / rd_data / wr_ack after a programmable latency from a small internal word-addressed memory.
- Used as the behavioural far-end in external-block tests, and as a real scratch window in integration.

Parameters:
- ADDR_WIDTH, 5: byte-address width of the mm window.
- DATA_WIDTH, 32: access width in bits; byte lanes = DATA_WIDTH/8.
- ACK_LATENCY, 2: cycles from the req cycle to the ack cycle; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- hwif_out_mm_req  in  1  request strobe, one cycle per access
- hwif_out_mm_req_is_wr  in  1  1 = write, 0 = read; valid with req
- hwif_out_mm_addr  in  ADDR_WIDTH  byte address; valid with req
- hwif_out_mm_wr_data  in  DATA_WIDTH  write data; valid with req
- hwif_out_mm_wr_biten  in  DATA_WIDTH  per-bit write enable; valid with req
- hwif_in_mm_rd_ack  out  1  read completion, one-cycle pulse
- hwif_in_mm_rd_data  out  DATA_WIDTH  read data; valid only with rd_ack, otherwise 0
- hwif_in_mm_wr_ack  out  1  write completion, one-cycle pulse
- busy  out  1  access outstanding (WAIT state)
- overrun  out  1  sticky: a req arrived while busy

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high.
- Reset values: rd_ack=0, wr_ack=0, rd_data=0, busy=0, overrun=0, FSM=IDLE, latency counter=0. All memory words clear to 0.
- Memory layout:
  - Words = 2**ADDR_WIDTH / (DATA_WIDTH/8); default 8.
  - Word index = addr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
- Request acceptance:
  - A req is accepted when FSM is IDLE or ACK.
  - Request processing happens on the accepting edge:
    - Write: mem[idx] <= (mem[idx] & ~wr_biten) | (wr_data & wr_biten).
    - Read: mem[idx] is captured into a holding register.
    - Operation type is latched.
  - A read accepted in the same cycle a write completes sees the completed write, because the write was already committed on its own accept edge.
- FSM states: IDLE, WAIT, ACK.
  - IDLE, on req:
    - ACK_LATENCY=1: go to ACK.
    - Otherwise: load counter = ACK_LATENCY-1 and go to WAIT.
  - WAIT: counter decrements each cycle; on counter==1, go to ACK. busy=1 throughout WAIT.
  - ACK: assert rd_ack (read) or wr_ack (write) for exactly this cycle; rd_data = holding register on a read.
    - No req: return to IDLE.
    - req present: accept it (back-to-back) and branch as from IDLE.
- Latency: req high in cycle T → ack high in cycle T+ACK_LATENCY, exactly one cycle. rd_ack and wr_ack are never both high.
- req while in WAIT:
  - The request is ignored: no memory update, no ack.
  - overrun <= 1 and stays set until rst.
  - The pending access completes normally.
- Reset mid-operation: a pending access is dropped with no ack, and memory clears. A req coincident with rst is ignored.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Basic write/read, ACK_LATENCY=2:
  - Stimulus: write addr 0x04, data 0xDEADBEEF, biten all-ones, req at cycle 10.
  - Required: wr_ack high at cycle 12 only, busy high in cycle 11.
  - Then read 0x04: rd_ack two cycles after its req, rd_data=0xDEADBEEF; rd_data=0 in all other cycles.
- Bit-enable merge:
  - Stimulus: mem[3]=0x12345678, then write addr 0x0C, data 0xFFFFFFFF, biten 0x0000FF00.
  - Required: readback 0x1234FF78.
  - Address aliasing: a read of 0x0E returns the same word.
- Back-to-back:
  - Stimulus: new req issued in the ACK cycle of the prior access.
  - Required: accepted; its ack follows ACK_LATENCY cycles later; overrun stays 0.
  - Repeat with ACK_LATENCY=1: an ack every cycle for 4 consecutive reads of words 0..3.
- Overrun:
  - Stimulus: write 0x55 to word 1 via a req issued during WAIT of a prior read.
  - Required: no extra ack; word 1 unchanged (re-read returns its previous value); overrun=1 and held until rst.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT of a write to word 2.
  - Required: no wr_ack; busy=0 next cycle; a subsequent read of word 2 returns 0.
- Latency sweep:
  - Stimulus: ACK_LATENCY in {1,3,15}, random read/write traffic against a scoreboard model.
  - Required: ack timing exact; data matches the model.
